i2c_reg_bank: RTL and testbench



---
 rtl/i2c_reg_pkg.sv | 16 +
 rtl/i2c_reg_stage_fifo.sv | 52 +++++
 rtl/i2c_reg_bank.sv | 186 ++++++++++++++++++
 tb/tb_i2c_reg_bank.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// rtl/i2c_reg_pkg.sv - shared widths, commit FSM states and staging entry type for i2c_reg_bank
package i2c_reg_pkg;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int LEN_W  = 9;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_COMMIT = 1'b1
    } commit_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } stage_entry_t;
endpackage

// File: rtl/i2c_reg_stage_fifo.sv
// rtl/i2c_reg_stage_fifo.sv - synchronous staging FIFO with simultaneous push/pop and occupancy
module i2c_reg_stage_fifo
    import i2c_reg_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  stage_entry_t               i_wdata,
    input  logic                       i_pop,
    output stage_entry_t               o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);
    localparam int AW = $clog2(DEPTH);

    stage_entry_t   r_mem [DEPTH];
    logic [AW-1:0]  r_wp;
    logic [AW-1:0]  r_rp;
    logic [AW:0]    r_count;
    logic           w_do_push;
    logic           w_do_pop;

    assign o_full    = (r_count == (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rp];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push) r_mem[r_wp] <= i_wdata;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wp <= r_wp + 1'b1;
            if (w_do_pop)  r_rp <= r_rp + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/i2c_reg_bank.sv
// rtl/i2c_reg_bank.sv - I2C slave register bank; I2C_REG_BANK_STAGE_EN enables atomic staged commit
module i2c_reg_bank
    import i2c_reg_pkg::*;
#(
    parameter int          DEPTH       = 32,
    parameter int          STAGE_DEPTH = 8,
    parameter logic [7:0]  RST_VAL     = 8'h00
) (
    input  logic                 i_sclk,
    input  logic                 i_rst,
    input  logic                 i_wr_de,
    input  logic [ADDR_W-1:0]    i_wr_addr,
    input  logic [DATA_W-1:0]    i_wr_data,
    input  logic                 i_wr_done,
    input  logic [LEN_W-1:0]     i_wr_length,
    input  logic                 i_rd_de,
    input  logic [ADDR_W-1:0]    i_rd_addr,
    output logic [DATA_W-1:0]    o_rd_data,
    output logic [DEPTH*8-1:0]   o_regs,
    output logic                 o_commit,
    output logic                 o_wr_err,
    output logic                 o_len_mismatch
);
    logic [DATA_W-1:0]  r_regs [DEPTH];
    logic [LEN_W-1:0]   r_cnt;
    logic               r_commit;
    logic               r_len_mis;
    logic               r_wr_err;
    logic [DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]  w_rd_val;
    logic               w_wr_in_range;
    logic               w_mis_now;
    logic               w_accept;
    logic               w_we;
    logic [ADDR_W-1:0]  w_waddr;
    logic [DATA_W-1:0]  w_wdata;
    logic               w_err;
    logic               w_fire;
    logic               w_fire_mis;

    assign w_wr_in_range = ({1'b0, i_wr_addr} < 9'(DEPTH));
    assign w_mis_now     = (i_wr_length != r_cnt);

`ifdef I2C_REG_BANK_STAGE_EN
    localparam int CNT_W = $clog2(STAGE_DEPTH) + 1;

    commit_state_t  r_state;
    commit_state_t  w_state_nxt;
    logic [CNT_W-1:0] r_left;
    logic           r_done_pend;
    logic           r_mis_pend;
    logic           r_mis_cur;
    logic           w_full;
    logic           w_empty;
    logic [CNT_W-1:0] w_count;
    logic [CNT_W-1:0] w_occ;
    logic           w_push_ok;
    logic           w_pop;
    logic           w_done_evt;
    logic           w_mis_sel;
    stage_entry_t   w_head;

    assign w_push_ok  = i_wr_de && w_wr_in_range && !w_full;
    assign w_occ      = w_count + CNT_W'(w_push_ok);
    assign w_done_evt = i_wr_done || r_done_pend;
    assign w_mis_sel  = r_done_pend ? r_mis_pend : w_mis_now;
    assign w_accept   = w_push_ok;
    assign w_err      = i_wr_de && (!w_wr_in_range || w_full);
    assign w_we       = w_pop;
    assign w_waddr    = w_head.addr;
    assign w_wdata    = w_head.data;

    i2c_reg_stage_fifo #(.DEPTH(STAGE_DEPTH)) u_stage_fifo (
        .i_clk   (i_sclk),
        .i_rst   (i_rst),
        .i_push  (w_push_ok),
        .i_wdata ({i_wr_addr, i_wr_data}),
        .i_pop   (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        w_fire      = 1'b0;
        w_fire_mis  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_done_evt) begin
                    if (w_occ != '0) begin
                        w_state_nxt = ST_COMMIT;
                    end else begin
                        w_fire     = 1'b1;
                        w_fire_mis = w_mis_sel;
                    end
                end
            end
            ST_COMMIT: begin
                w_pop = !w_empty;
                if (r_left == CNT_W'(1)) begin
                    w_fire      = 1'b1;
                    w_fire_mis  = r_mis_cur;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // A done arriving while busy (or while a pending one is being consumed) waits its turn.
    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_left      <= '0;
            r_done_pend <= 1'b0;
            r_mis_pend  <= 1'b0;
            r_mis_cur   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_done_evt) begin
                r_left    <= w_occ;
                r_mis_cur <= w_mis_sel;
            end else if (r_state == ST_COMMIT) begin
                r_left <= r_left - 1'b1;
            end
            if (i_wr_done && (r_state == ST_COMMIT || r_done_pend)) begin
                r_done_pend <= 1'b1;
                r_mis_pend  <= w_mis_now;
            end else if (r_state == ST_IDLE) begin
                r_done_pend <= 1'b0;
            end
        end
    end
`else
    assign w_accept   = i_wr_de && w_wr_in_range;
    assign w_err      = i_wr_de && !w_wr_in_range;
    assign w_we       = w_accept;
    assign w_waddr    = i_wr_addr;
    assign w_wdata    = i_wr_data;
    assign w_fire     = i_wr_done;
    assign w_fire_mis = i_wr_done && w_mis_now;
`endif

    always_comb begin
        w_rd_val = '0;
        for (int n = 0; n < DEPTH; n++) begin
            if (i_rd_addr == 8'(n)) w_rd_val = r_regs[n];
        end
    end

    always_ff @(posedge i_sclk) begin
        if (i_rst) begin
            for (int n = 0; n < DEPTH; n++) r_regs[n] <= RST_VAL;
            r_cnt     <= '0;
            r_commit  <= 1'b0;
            r_len_mis <= 1'b0;
            r_wr_err  <= 1'b0;
            r_rd_data <= '0;
        end else begin
            for (int n = 0; n < DEPTH; n++) begin
                if (w_we && w_waddr == 8'(n)) r_regs[n] <= w_wdata;
            end
            // A byte coinciding with done opens the next transaction.
            if (i_wr_done)
                r_cnt <= w_accept ? LEN_W'(1) : '0;
            else if (w_accept && r_cnt != '1)
                r_cnt <= r_cnt + 1'b1;
            r_commit  <= w_fire;
            r_len_mis <= w_fire_mis;
            r_wr_err  <= w_err;
            if (i_rd_de) r_rd_data <= w_rd_val;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_regs
        assign o_regs[8*g +: 8] = r_regs[g];
    end

    assign o_rd_data      = r_rd_data;
    assign o_commit       = r_commit;
    assign o_wr_err       = r_wr_err;
    assign o_len_mismatch = r_len_mis;
endmodule

// File: tb/tb_i2c_reg_bank.sv
// tb/tb_i2c_reg_bank.sv - directed scoreboard bench for i2c_reg_bank (both builds of I2C_REG_BANK_STAGE_EN)
module tb_i2c_reg_bank;
    localparam int         DEPTH = 32;
    localparam int         SDEP  = 8;
    localparam logic [7:0] RSTV  = 8'h3C;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               wr_de = 1'b0;
    logic [7:0]         wr_addr = '0;
    logic [7:0]         wr_data = '0;
    logic               wr_done = 1'b0;
    logic [8:0]         wr_len = '0;
    logic               rd_de = 1'b0;
    logic [7:0]         rd_addr = '0;
    logic [7:0]         rd_data;
    logic [DEPTH*8-1:0] regs;
    logic               commit;
    logic               wr_err;
    logic               len_mis;

    int          n_checks = 0;
    int          n_err = 0;
    logic [7:0]  m_regs [DEPTH];
    logic [7:0]  q_exp [$];

    i2c_reg_bank #(.DEPTH(DEPTH), .STAGE_DEPTH(SDEP), .RST_VAL(RSTV)) dut (
        .i_sclk         (clk),
        .i_rst          (rst),
        .i_wr_de        (wr_de),
        .i_wr_addr      (wr_addr),
        .i_wr_data      (wr_data),
        .i_wr_done      (wr_done),
        .i_wr_length    (wr_len),
        .i_rd_de        (rd_de),
        .i_rd_addr      (rd_addr),
        .o_rd_data      (rd_data),
        .o_regs         (regs),
        .o_commit       (commit),
        .o_wr_err       (wr_err),
        .o_len_mismatch (len_mis)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DEPTH*8-1:0] obs, input logic [DEPTH*8-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DEPTH*8-1:0] model_vec();
        logic [DEPTH*8-1:0] v;
        for (int n = 0; n < DEPTH; n++) v[8*n +: 8] = m_regs[n];
        return v;
    endfunction

    task automatic model_reset();
        for (int n = 0; n < DEPTH; n++) m_regs[n] = RSTV;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        wr_de = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_de = 1'b0;
    endtask

    task automatic done(input logic [8:0] len);
        wr_done = 1'b1; wr_len = len;
        tick();
        wr_done = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        logic [7:0] e;
        q_exp.push_back(exp);
        rd_de = 1'b1; rd_addr = a;
        tick();
        rd_de = 1'b0;
        e = q_exp.pop_front();
        chk(tag, rd_data, e);
    endtask

    initial begin
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_rd_data", rd_data, 0);
        chk("rst_commit", commit, 0);
        chk("rst_wr_err", wr_err, 0);
        chk("rst_len_mis", len_mis, 0);
        chk("rst_regs", regs, model_vec());
        rd("rd_rst_addr5", 8'd5, RSTV);

        wr(8'd3, 8'hA5);
        chk("wr3_err", wr_err, 0);
`ifndef I2C_REG_BANK_STAGE_EN
        m_regs[3] = 8'hA5;
`endif
        chk("wr3_regs", regs, model_vec());
        wr(8'd4, 8'h5A);
`ifndef I2C_REG_BANK_STAGE_EN
        m_regs[4] = 8'h5A;
`endif
        chk("wr4_regs", regs, model_vec());
        done(9'd2);
`ifdef I2C_REG_BANK_STAGE_EN
        chk("t1_commit_p1", commit, 0);
        chk("t1_regs_p1", regs, model_vec());
        tick();
        m_regs[3] = 8'hA5;
        chk("t1_regs_p2", regs, model_vec());
        tick();
        m_regs[4] = 8'h5A;
`endif
        chk("t1_commit", commit, 1);
        chk("t1_len_mis", len_mis, 0);
        chk("t1_regs", regs, model_vec());
        tick();
        chk("t1_commit_off", commit, 0);
        rd("rd_addr3", 8'd3, 8'hA5);
        rd("rd_addr4", 8'd4, 8'h5A);

        wr(8'd40, 8'h11);
        chk("oob_err", wr_err, 1);
        chk("oob_regs", regs, model_vec());
        tick();
        chk("oob_err_off", wr_err, 0);
        done(9'd1);
        chk("oob_commit", commit, 1);
        chk("oob_len_mis", len_mis, 1);
        rd("rd_oob", 8'd40, 8'h00);

`ifdef I2C_REG_BANK_STAGE_EN
        for (int i = 0; i < 9; i++) begin
            wr(8'(8 + i), 8'(8'h80 + i));
            chk($sformatf("ovf_err_%0d", i), wr_err, (i == 8) ? 1 : 0);
        end
        done(9'd9);
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("ovf_commit_p%0d", k), commit, 0);
            tick();
        end
        chk("ovf_commit_p9", commit, 1);
        for (int i = 0; i < 8; i++) m_regs[8 + i] = 8'(8'h80 + i);
        chk("ovf_regs", regs, model_vec());
        tick();

        wr(8'd20, 8'h21);
        wr(8'd21, 8'h22);
        done(9'd2);
        wr(8'd22, 8'h33);
        wr(8'd23, 8'h44);
        chk("ovl_commit1", commit, 1);
        chk("ovl_len_mis1", len_mis, 0);
        m_regs[20] = 8'h21; m_regs[21] = 8'h22;
        chk("ovl_regs1", regs, model_vec());
        tick();
        done(9'd2);
        tick();
        tick();
        chk("ovl_commit2", commit, 1);
        chk("ovl_len_mis2", len_mis, 0);
        m_regs[22] = 8'h33; m_regs[23] = 8'h44;
        chk("ovl_regs2", regs, model_vec());
        rd("rd_addr22", 8'd22, 8'h33);

        wr(8'd24, 8'h61);
        wr(8'd25, 8'h62);
        wr(8'd26, 8'h63);
        done(9'd3);
        tick();
        rst = 1'b1;
        tick();
        model_reset();
        chk("mid_rst_regs", regs, model_vec());
        chk("mid_rst_commit", commit, 0);
        rst = 1'b0;
        tick();
        chk("post_rst_commit", commit, 0);
        done(9'd0);
        chk("empty_commit", commit, 1);
        chk("empty_len_mis", len_mis, 0);
        chk("empty_regs", regs, model_vec());
        rd("rd_addr24", 8'd24, RSTV);
`else
        wr(8'd6, 8'h77);
        m_regs[6] = 8'h77;
        chk("dir_wr6_regs", regs, model_vec());
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk("dir_rst_regs", regs, model_vec());
        rd("rd_addr6", 8'd6, RSTV);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end
endmodule
